// File: rtl/alu_issue_seq.sv
// -----------------------------------------------------------------------------
// alu_issue_seq
//
// Issue sequencer for the data-processing ALU. Takes one decoded ARM
// data-processing instruction at a time, fetches Rs when the instruction uses
// a register-specified shift, rewrites that shift into an immediate-shift form
// the combinational alu understands, evaluates the condition code against the
// committed CPSR flags, and hands the result to the register-file writeback
// port. The NZCV flags are owned and committed here.
//
// Sequence: IDLE -> (RS_FETCH) -> EXEC -> WB -> IDLE. One instruction in flight.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   in_valid/in_ready         decode handshake; in_ready high only in IDLE
//   in_inst/in_rn_val/in_rm_val  instruction word and Rn/Rm operand values
//   rs_rd_en/rs_rd_addr       Rs read request (one cycle, in RS_FETCH)
//   rs_rd_data                Rs value, sampled on the edge closing RS_FETCH
//   alu_inst/alu_regA/alu_regB   operands presented to the alu
//   alu_out/alu_nzcv/alu_upd_cpsr/alu_ign_c   alu results
//   wb_valid/wb_ready         writeback handshake
//   wb_we/wb_rd/wb_data       writeback enable, destination index, data
//   cpsr_nzcv                 committed {N,Z,C,V}
//
// Optional feature (macro ALU_SEQ_STATS_EN):
//   adds stat_retired[31:0] and stat_cond_fail[31:0], counting WB handshakes
//   and condition-failed retirements. Both wrap and reset to zero.
// -----------------------------------------------------------------------------
module alu_issue_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_rn_val,
    input  logic [31:0] in_rm_val,
    output logic        rs_rd_en,
    output logic [3:0]  rs_rd_addr,
    input  logic [31:0] rs_rd_data,
    output logic [31:0] alu_inst,
    output logic [31:0] alu_regA,
    output logic [31:0] alu_regB,
    input  logic [31:0] alu_out,
    input  logic [3:0]  alu_nzcv,
    input  logic        alu_upd_cpsr,
    input  logic        alu_ign_c,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_we,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [3:0]  cpsr_nzcv
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [31:0] stat_retired,
    output logic [31:0] stat_cond_fail
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RS_FETCH = 2'd1,
        ST_EXEC     = 2'd2,
        ST_WB       = 2'd3
    } state_t;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] rn_q, rn_d;
    logic [31:0] rm_q, rm_d;
    logic [7:0]  amt_q, amt_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [3:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [3:0]  cpsr_q, cpsr_d;

    // Only the low byte of Rs is a shift amount.
    logic unused_rs_hi;
    assign unused_rs_hi = ^rs_rd_data[31:8];

    // ------------------------------------------------------------------
    // Instruction field decode of the latched instruction
    // ------------------------------------------------------------------
    logic       reg_shift;
    logic [3:0] opcode;
    logic       is_test_op;
    logic       is_arith_op;
    logic       is_logic_op;

    assign reg_shift   = !inst_q[25] && inst_q[4];
    assign opcode      = inst_q[24:21];
    assign is_test_op  = (opcode[3:2] == 2'b10);
    assign is_arith_op = ((opcode >= 4'd2) && (opcode <= 4'd7)) ||
                         (opcode == 4'd10) || (opcode == 4'd11);
    assign is_logic_op = !is_arith_op;

    // ------------------------------------------------------------------
    // Shift-field rewrite and sequencer carry override.
    // A register shift is turned into an immediate shift; amounts the
    // immediate encoding cannot express (0 and >=32) are resolved here by
    // substituting regB and/or supplying the shifter carry directly.
    // ------------------------------------------------------------------
    logic c_ovr_en;
    logic c_ovr_val;

    always_comb begin
        alu_inst  = inst_q;
        alu_regA  = rn_q;
        alu_regB  = rm_q;
        c_ovr_en  = 1'b0;
        c_ovr_val = 1'b0;
        if (reg_shift) begin
            alu_inst[4] = 1'b0;
            if (amt_q == 8'd0) begin
                // LSL #0 pass-through; the shifter carry is the old C.
                alu_inst[11:5] = 7'd0;
                c_ovr_en       = 1'b1;
                c_ovr_val      = cpsr_q[1];
            end else if (amt_q < 8'd32) begin
                alu_inst[11:7] = amt_q[4:0];
            end else begin
                case (inst_q[6:5])
                    SH_LSL, SH_LSR: begin
                        alu_regB       = 32'd0;
                        alu_inst[11:5] = 7'd0;
                        c_ovr_en       = 1'b1;
                        if (amt_q == 8'd32)
                            c_ovr_val = (inst_q[6:5] == SH_LSL) ? rm_q[0] : rm_q[31];
                        else
                            c_ovr_val = 1'b0;
                    end
                    SH_ASR: begin
                        alu_regB       = {32{rm_q[31]}};
                        alu_inst[11:5] = 7'd0;
                        c_ovr_en       = 1'b1;
                        c_ovr_val      = rm_q[31];
                    end
                    default: begin
                        // ROR by a multiple of 32 leaves the value intact,
                        // but the carry is still bit 31.
                        if (amt_q[4:0] == 5'd0) begin
                            alu_inst[11:5] = 7'd0;
                            c_ovr_en       = 1'b1;
                            c_ovr_val      = rm_q[31];
                        end else begin
                            alu_inst[11:7] = amt_q[4:0];
                        end
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Condition evaluation against the committed flags
    // ------------------------------------------------------------------
    logic cond_pass;

    always_comb begin
        cond_pass = 1'b0;
        case (inst_q[31:28])
            4'h0: cond_pass = cpsr_q[2];
            4'h1: cond_pass = !cpsr_q[2];
            4'h2: cond_pass = cpsr_q[1];
            4'h3: cond_pass = !cpsr_q[1];
            4'h4: cond_pass = cpsr_q[3];
            4'h5: cond_pass = !cpsr_q[3];
            4'h6: cond_pass = cpsr_q[0];
            4'h7: cond_pass = !cpsr_q[0];
            4'h8: cond_pass = cpsr_q[1] && !cpsr_q[2];
            4'h9: cond_pass = !cpsr_q[1] || cpsr_q[2];
            4'hA: cond_pass = (cpsr_q[3] == cpsr_q[0]);
            4'hB: cond_pass = (cpsr_q[3] != cpsr_q[0]);
            4'hC: cond_pass = !cpsr_q[2] && (cpsr_q[3] == cpsr_q[0]);
            4'hD: cond_pass = cpsr_q[2] || (cpsr_q[3] != cpsr_q[0]);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Flag merge. The override only replaces the shifter carry, so it is
    // used for logical opcodes; arithmetic opcodes take the adder carry.
    // ------------------------------------------------------------------
    logic c_new;
    logic v_new;

    always_comb begin
        if (c_ovr_en && is_logic_op)
            c_new = c_ovr_val;
        else if (alu_ign_c)
            c_new = cpsr_q[1];
        else
            c_new = alu_nzcv[1];
        v_new = is_arith_op ? alu_nzcv[0] : cpsr_q[0];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        rn_d       = rn_q;
        rm_d       = rm_q;
        amt_d      = amt_q;
        wb_valid_d = wb_valid_q;
        wb_we_d    = wb_we_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        cpsr_d     = cpsr_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    inst_d  = in_inst;
                    rn_d    = in_rn_val;
                    rm_d    = in_rm_val;
                    state_d = (!in_inst[25] && in_inst[4]) ? ST_RS_FETCH : ST_EXEC;
                end
            end
            ST_RS_FETCH: begin
                amt_d   = rs_rd_data[7:0];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                wb_data_d  = alu_out;
                wb_rd_d    = inst_q[15:12];
                wb_valid_d = 1'b1;
                wb_we_d    = cond_pass && !is_test_op;
                if (cond_pass && alu_upd_cpsr)
                    cpsr_d = {alu_nzcv[3], alu_nzcv[2], c_new, v_new};
                state_d = ST_WB;
            end
            default: begin
                if (wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            inst_q     <= 32'd0;
            rn_q       <= 32'd0;
            rm_q       <= 32'd0;
            amt_q      <= 8'd0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= 4'd0;
            wb_data_q  <= 32'd0;
            cpsr_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            rn_q       <= rn_d;
            rm_q       <= rm_d;
            amt_q      <= amt_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            cpsr_q     <= cpsr_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign rs_rd_en   = (state_q == ST_RS_FETCH);
    assign rs_rd_addr = inst_q[11:8];
    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign cpsr_nzcv  = cpsr_q;

`ifdef ALU_SEQ_STATS_EN
    // Retirement statistics, counted on the writeback handshake.
    logic        cond_fail_q, cond_fail_d;
    logic [31:0] stat_retired_q, stat_retired_d;
    logic [31:0] stat_cond_fail_q, stat_cond_fail_d;

    always_comb begin
        cond_fail_d      = cond_fail_q;
        stat_retired_d   = stat_retired_q;
        stat_cond_fail_d = stat_cond_fail_q;
        if (state_q == ST_EXEC)
            cond_fail_d = !cond_pass;
        if ((state_q == ST_WB) && wb_ready) begin
            stat_retired_d = stat_retired_q + 32'd1;
            if (cond_fail_q)
                stat_cond_fail_d = stat_cond_fail_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond_fail_q      <= 1'b0;
            stat_retired_q   <= 32'd0;
            stat_cond_fail_q <= 32'd0;
        end else begin
            cond_fail_q      <= cond_fail_d;
            stat_retired_q   <= stat_retired_d;
            stat_cond_fail_q <= stat_cond_fail_d;
        end
    end

    assign stat_retired   = stat_retired_q;
    assign stat_cond_fail = stat_cond_fail_q;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_seq
//
// Table-driven bench for alu_issue_seq. A small behavioural data-processing
// alu sits on the alu_* ports; each table record holds one instruction, its
// operands and the hand-computed writeback, flags and latency. Records run in
// order so the flag state carries from one to the next. A hand-written
// sequence covers reset during RS_FETCH.
// -----------------------------------------------------------------------------
module tb_alu_issue_seq;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_rn_val;
    logic [31:0] in_rm_val;
    logic        rs_rd_en;
    logic [3:0]  rs_rd_addr;
    logic [31:0] rs_rd_data;
    logic [31:0] alu_inst;
    logic [31:0] alu_regA;
    logic [31:0] alu_regB;
    logic [31:0] alu_out;
    logic [3:0]  alu_nzcv;
    logic        alu_upd_cpsr;
    logic        alu_ign_c;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  cpsr_nzcv;

    logic [31:0] rs_val;
    int          checks;
    int          failures;

    alu_issue_seq dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_rn_val    (in_rn_val),
        .in_rm_val    (in_rm_val),
        .rs_rd_en     (rs_rd_en),
        .rs_rd_addr   (rs_rd_addr),
        .rs_rd_data   (rs_rd_data),
        .alu_inst     (alu_inst),
        .alu_regA     (alu_regA),
        .alu_regB     (alu_regB),
        .alu_out      (alu_out),
        .alu_nzcv     (alu_nzcv),
        .alu_upd_cpsr (alu_upd_cpsr),
        .alu_ign_c    (alu_ign_c),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .cpsr_nzcv    (cpsr_nzcv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file read port: data only meaningful while the request is up.
    assign rs_rd_data = rs_rd_en ? rs_val : 32'hDEADBEEF;

    // ------------------------------------------------------------------
    // Behavioural alu: immediate operands and immediate shifts only
    // (shift #0 treated as pass-through).
    // ------------------------------------------------------------------
    always_comb begin
        logic [31:0] b_sh;
        logic [31:0] tmp;
        logic [31:0] a;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic [32:0] sum;
        logic        sh_c;
        logic        no_c;
        logic        cin;
        logic        arith;
        logic        ci;
        logic        c_o;
        logic        v_o;
        int          amt;

        a     = alu_regA;
        cin   = cpsr_nzcv[1];
        b_sh  = alu_regB;
        sh_c  = cin;
        no_c  = 1'b1;
        tmp   = 32'd0;
        x     = 32'd0;
        y     = 32'd0;
        ci    = 1'b0;
        arith = 1'b0;
        res   = 32'd0;
        sum   = 33'd0;
        if (alu_inst[25]) begin
            amt = 2 * int'(alu_inst[11:8]);
            tmp = {24'd0, alu_inst[7:0]};
            b_sh = tmp;
            if (amt != 0) begin
                b_sh = (tmp >> amt) | (tmp << (32 - amt));
                sh_c = b_sh[31];
                no_c = 1'b0;
            end
        end else begin
            amt = int'(alu_inst[11:7]);
            if (amt != 0) begin
                no_c = 1'b0;
                case (alu_inst[6:5])
                    2'b00: begin
                        b_sh = alu_regB << amt;
                        tmp  = alu_regB >> (32 - amt);
                        sh_c = tmp[0];
                    end
                    2'b01: begin
                        b_sh = alu_regB >> amt;
                        tmp  = alu_regB >> (amt - 1);
                        sh_c = tmp[0];
                    end
                    2'b10: begin
                        b_sh = $signed(alu_regB) >>> amt;
                        tmp  = $signed(alu_regB) >>> (amt - 1);
                        sh_c = tmp[0];
                    end
                    default: begin
                        b_sh = (alu_regB >> amt) | (alu_regB << (32 - amt));
                        sh_c = b_sh[31];
                    end
                endcase
            end
        end
        c_o = sh_c;
        v_o = cpsr_nzcv[0];
        case (alu_inst[24:21])
            4'd0, 4'd8:  res = a & b_sh;
            4'd1, 4'd9:  res = a ^ b_sh;
            4'd12:       res = a | b_sh;
            4'd13:       res = b_sh;
            4'd14:       res = a & ~b_sh;
            4'd15:       res = ~b_sh;
            4'd2, 4'd10: begin arith = 1'b1; x = a;    y = ~b_sh; ci = 1'b1; end
            4'd3:        begin arith = 1'b1; x = b_sh; y = ~a;    ci = 1'b1; end
            4'd4, 4'd11: begin arith = 1'b1; x = a;    y = b_sh;  ci = 1'b0; end
            4'd5:        begin arith = 1'b1; x = a;    y = b_sh;  ci = cin;  end
            4'd6:        begin arith = 1'b1; x = a;    y = ~b_sh; ci = cin;  end
            default:     begin arith = 1'b1; x = b_sh; y = ~a;    ci = cin;  end
        endcase
        if (arith) begin
            sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
            res = sum[31:0];
            c_o = sum[32];
            v_o = (x[31] == y[31]) && (res[31] != x[31]);
        end
        alu_out      = res;
        alu_nzcv     = {res[31], (res == 32'd0), c_o, v_o};
        alu_upd_cpsr = alu_inst[20];
        alu_ign_c    = !arith && no_c;
    end

    // ------------------------------------------------------------------
    // Comparison helper
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [31:0] rs;
        int          hold;
        logic        exp_we;
        logic [3:0]  exp_rd;
        logic [31:0] exp_data;
        logic [3:0]  exp_nzcv;
        int          exp_lat;
    } vec_t;

    // Apply one instruction from IDLE and follow it through writeback.
    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        int          rs_cnt;
        logic        s_we;
        logic [3:0]  s_rd;
        logic [31:0] s_data;
        chk($sformatf("v%0d in_ready_idle", idx), {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_inst   = v.inst;
        in_rn_val = v.rn;
        in_rm_val = v.rm;
        rs_val    = v.rs;
        wb_ready  = (v.hold == 0);
        @(posedge clk); #1;
        // Scramble the inputs to prove the operands were latched.
        in_valid  = 1'b0;
        in_inst   = 32'hFFFF_FFFF;
        in_rn_val = 32'hA5A5_A5A5;
        in_rm_val = 32'h5A5A_5A5A;
        lat       = 1;
        rs_cnt    = 0;
        while (!wb_valid && lat < 8) begin
            chk($sformatf("v%0d in_ready_busy", idx), {31'd0, in_ready}, 32'd0);
            if (rs_rd_en) begin
                rs_cnt++;
                chk($sformatf("v%0d rs_rd_addr", idx), {28'd0, rs_rd_addr}, {28'd0, v.inst[11:8]});
            end
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d rs_req_cycles", idx), rs_cnt, (v.exp_lat == 3) ? 1 : 0);
        chk($sformatf("v%0d wb_we", idx), {31'd0, wb_we}, {31'd0, v.exp_we});
        chk($sformatf("v%0d wb_rd", idx), {28'd0, wb_rd}, {28'd0, v.exp_rd});
        chk($sformatf("v%0d wb_data", idx), wb_data, v.exp_data);
        chk($sformatf("v%0d cpsr", idx), {28'd0, cpsr_nzcv}, {28'd0, v.exp_nzcv});
        s_we   = wb_we;
        s_rd   = wb_rd;
        s_data = wb_data;
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            chk($sformatf("v%0d hold_valid", idx), {31'd0, wb_valid}, 32'd1);
            chk($sformatf("v%0d hold_data", idx), wb_data, v.exp_data);
            chk($sformatf("v%0d hold_rd_we", idx), {27'd0, wb_we, wb_rd}, {27'd0, v.exp_we, v.exp_rd});
            chk($sformatf("v%0d hold_in_ready", idx), {31'd0, in_ready}, 32'd0);
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("v%0d wb_valid_clear", idx), {31'd0, wb_valid}, 32'd0);
        chk($sformatf("v%0d in_ready_back", idx), {31'd0, in_ready}, 32'd1);
        chk($sformatf("v%0d cpsr_after", idx), {28'd0, cpsr_nzcv}, {28'd0, v.exp_nzcv});
        $display("txn %0d inst=%h we=%0d rd=%0d data=%h nzcv=%b lat=%0d",
                 idx, v.inst, s_we, s_rd, s_data, cpsr_nzcv, lat);
    endtask

    vec_t vecs[16];
    vec_t mov_vec;

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'd0;
        in_rn_val = 32'd0;
        in_rm_val = 32'd0;
        wb_ready  = 1'b1;
        rs_val    = 32'd0;

        //            inst          rn            rm            rs         hold we rd    data          nzcv     lat
        vecs[0]  = '{32'hE3A010FF, 32'h0,        32'h0,        32'h0,     0, 1, 4'd1, 32'h000000FF, 4'b0000, 2}; // MOV r1,#0xFF
        vecs[1]  = '{32'hE0902001, 32'h7FFFFFFF, 32'h1,        32'h0,     0, 1, 4'd2, 32'h80000000, 4'b1001, 2}; // ADDS r2,r0,r1
        vecs[2]  = '{32'h03A03005, 32'h0,        32'h0,        32'h0,     0, 0, 4'd3, 32'h00000005, 4'b1001, 2}; // MOVEQ (Z=0)
        vecs[3]  = '{32'hE1B04615, 32'h0,        32'h1,        32'd40,    0, 1, 4'd4, 32'h00000000, 4'b0101, 3}; // LSL r6=40
        vecs[4]  = '{32'hE1B04615, 32'h0,        32'h1,        32'd32,    0, 1, 4'd4, 32'h00000000, 4'b0111, 3}; // LSL r6=32
        vecs[5]  = '{32'hE1B04615, 32'h0,        32'h1,        32'd0,     0, 1, 4'd4, 32'h00000001, 4'b0011, 3}; // LSL r6=0
        vecs[6]  = '{32'hE1B07958, 32'h0,        32'h80000000, 32'h140,   0, 1, 4'd7, 32'hFFFFFFFF, 4'b1011, 3}; // ASR by 64
        vecs[7]  = '{32'hE1B01372, 32'h0,        32'h00000001, 32'd32,    0, 1, 4'd1, 32'h00000001, 4'b0001, 3}; // ROR by 32
        vecs[8]  = '{32'hE1B01332, 32'h0,        32'h80000000, 32'd32,    0, 1, 4'd1, 32'h00000000, 4'b0111, 3}; // LSR by 32
        vecs[9]  = '{32'hE1B01312, 32'h0,        32'h0000000F, 32'd4,     0, 1, 4'd1, 32'h000000F0, 4'b0001, 3}; // LSL by 4
        vecs[10] = '{32'hE1B01372, 32'h0,        32'h0000000F, 32'h24,    0, 1, 4'd1, 32'hF0000000, 4'b1011, 3}; // ROR by 36
        vecs[11] = '{32'hE0565007, 32'h5,        32'h7,        32'h0,     0, 1, 4'd5, 32'hFFFFFFFE, 4'b1000, 2}; // SUBS 5-7
        vecs[12] = '{32'hF3A010FF, 32'h0,        32'h0,        32'h0,     0, 0, 4'd1, 32'h000000FF, 4'b1000, 2}; // cond 1111
        vecs[13] = '{32'hE1500000, 32'h1234,     32'h1234,     32'h0,     5, 0, 4'd0, 32'h00000000, 4'b0110, 2}; // CMP r0,r0
        vecs[14] = '{32'hA0809001, 32'h3,        32'h4,        32'h0,     0, 1, 4'd9, 32'h00000007, 4'b0110, 2}; // ADDGE
        vecs[15] = '{32'hE0121003, 32'hFFFFFFFF, 32'h80000000, 32'h0,     0, 1, 4'd1, 32'h80000000, 4'b1010, 2}; // ANDS
        mov_vec  = '{32'hE3A010FF, 32'h0,        32'h0,        32'h0,     0, 1, 4'd1, 32'h000000FF, 4'b0000, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst rs_rd_en", {31'd0, rs_rd_en}, 32'd0);
        chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst wb_rd", {28'd0, wb_rd}, 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst cpsr", {28'd0, cpsr_nzcv}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++)
            run_vec(vecs[i], i);

        // Reset while Rs is being fetched: transaction must vanish.
        in_valid  = 1'b1;
        in_inst   = 32'hE1B04615;
        in_rn_val = 32'h0;
        in_rm_val = 32'h1;
        rs_val    = 32'd3;
        wb_ready  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rstmid in_rs_fetch", {31'd0, rs_rd_en}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstmid wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rstmid in_ready", {31'd0, in_ready}, 32'd1);
        chk("rstmid rs_rd_en", {31'd0, rs_rd_en}, 32'd0);
        chk("rstmid cpsr", {28'd0, cpsr_nzcv}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("rstmid no_wb", {31'd0, wb_valid}, 32'd0);
        end
        $display("txn reset-during-rs_fetch wb_valid=%0d nzcv=%b", wb_valid, cpsr_nzcv);
        run_vec(mov_vec, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
